// File: rtl/bs_pkg.sv
// Shared types and defaults for the bit-serial program sequencer.
package bs_pkg;

  // Default instruction width; the core consumes 3-bit instructions.
  localparam int INSTR_W = 3;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  // Instruction word at the default width.
  typedef logic [INSTR_W-1:0] instr_t;

  // True when a load is allowed, i.e. the program is not executing.
  function automatic logic load_allowed(input seq_state_t st);
    return (st != RUN);
  endfunction

endpackage

// File: rtl/bs_prog_mem.sv
// Program memory: DEPTH x INSTR_W words, cleared by reset,
// one synchronous write port and one combinational read port.
module bs_prog_mem #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 3,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [INSTR_W-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Storage: clear every word on reset, otherwise write one word when enabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port is combinational so a pc change shows the new word without delay.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bs_program_sequencer.sv
// Instruction supply for the bit-serial core: program memory, program
// counter, and the IDLE/RUN/HALT control that loads, starts and stops it.
module bs_program_sequencer
  import bs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = bs_pkg::INSTR_W,
  parameter int WRAP    = 0,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_load_we,
  input  logic [AW-1:0]      i_load_addr,
  input  logic [INSTR_W-1:0] i_load_data,
  input  logic               i_con_pcincr,
  output logic [INSTR_W-1:0] o_data_instruction,
  output logic               o_core_start,
  output logic [AW-1:0]      o_pc,
  output logic               o_running,
  output logic               o_halted
);

  localparam logic [AW-1:0] LP_LAST_PC = AW'(DEPTH - 1);
  localparam logic [AW-1:0] LP_ONE     = AW'(1);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_nxt;
  logic          r_core_start;
  logic          w_core_start_nxt;
  logic          w_mem_we;

  // Registered control: state, program counter and the one-cycle start pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_pc         <= '0;
      r_core_start <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_core_start <= w_core_start_nxt;
    end
  end

  // Next-state logic: start/restart from IDLE or HALT, pc stepping in RUN.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_core_start_nxt = 1'b0;
    w_mem_we         = 1'b0;
    case (r_state)
      IDLE, HALT: begin
        // A load and a start in the same cycle both take effect.
        w_mem_we = i_load_we & load_allowed(r_state);
        if (i_start) begin
          w_state_nxt      = RUN;
          w_pc_nxt         = '0;
          w_core_start_nxt = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      RUN: begin
        // Start and load requests are ignored while executing.
        if (i_con_pcincr) begin
          if (r_pc != LP_LAST_PC) begin
            w_pc_nxt = r_pc + LP_ONE;
          end else if (WRAP != 0) begin
            w_pc_nxt = '0;
          end else begin
            // Stop on the last word and keep pointing at it.
            w_state_nxt = HALT;
            w_pc_nxt    = r_pc;
          end
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      default: begin
        // Unreachable encoding: recover to a safe idle state.
        w_state_nxt = IDLE;
        w_pc_nxt    = '0;
      end
    endcase
  end

  bs_prog_mem #(
    .DEPTH  (DEPTH),
    .INSTR_W(INSTR_W),
    .AW     (AW)
  ) u_prog_mem (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (w_mem_we),
    .i_waddr(i_load_addr),
    .i_wdata(i_load_data),
    .i_raddr(r_pc),
    .o_rdata(o_data_instruction)
  );

  // Status flags decode straight from the state register, so they cannot glitch.
  assign o_core_start = r_core_start;
  assign o_pc         = r_pc;
  assign o_running    = (r_state == RUN);
  assign o_halted     = (r_state == HALT);

endmodule

// File: tb/tb_bs_program_sequencer.sv
// Self-checking bench: two sequencers share the stimulus, one halting at the
// end of the program (WRAP=0) and one wrapping (WRAP=1). Expected outputs are
// queued per cycle as stimulus is driven and compared after the clock edge.
module tb_bs_program_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       load_we;
  logic [1:0] load_addr;
  logic [2:0] load_data;
  logic       pcincr;

  logic [2:0] instr_h, instr_w;
  logic       cs_h, cs_w;
  logic [1:0] pc_h, pc_w;
  logic       run_h, run_w;
  logic       halt_h, halt_w;

  int n_checks;
  int n_errors;

  typedef struct packed {
    logic [1:0] pc;
    logic [2:0] instr;
    logic       run;
    logic       halt;
    logic       cs;
  } exp_t;

  exp_t q_h[$];
  exp_t q_w[$];

  bs_program_sequencer #(.DEPTH(4), .INSTR_W(3), .WRAP(0)) dut_halt (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_load_we(load_we),
    .i_load_addr(load_addr), .i_load_data(load_data), .i_con_pcincr(pcincr),
    .o_data_instruction(instr_h), .o_core_start(cs_h), .o_pc(pc_h),
    .o_running(run_h), .o_halted(halt_h)
  );

  bs_program_sequencer #(.DEPTH(4), .INSTR_W(3), .WRAP(1)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_load_we(load_we),
    .i_load_addr(load_addr), .i_load_data(load_data), .i_con_pcincr(pcincr),
    .o_data_instruction(instr_w), .o_core_start(cs_w), .o_pc(pc_w),
    .o_running(run_w), .o_halted(halt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] pc, input logic [2:0] instr,
                              input logic run, input logic halt, input logic cs);
    exp_t e;
    e.pc = pc; e.instr = instr; e.run = run; e.halt = halt; e.cs = cs;
    return e;
  endfunction

  task automatic compare_one(input string who, input exp_t e, input logic [1:0] pc,
                             input logic [2:0] instr, input logic run,
                             input logic halt, input logic cs);
    check_eq({who, ".pc"},    32'(pc),    32'(e.pc));
    check_eq({who, ".instr"}, 32'(instr), 32'(e.instr));
    check_eq({who, ".run"},   32'(run),   32'(e.run));
    check_eq({who, ".halt"},  32'(halt),  32'(e.halt));
    check_eq({who, ".start"}, 32'(cs),    32'(e.cs));
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic cycle(input logic st, input logic we, input logic [1:0] addr,
                       input logic [2:0] data, input logic inc,
                       input exp_t eh, input exp_t ew);
    exp_t ph, pw;
    @(negedge clk);
    start = st; load_we = we; load_addr = addr; load_data = data; pcincr = inc;
    q_h.push_back(eh);
    q_w.push_back(ew);
    @(posedge clk);
    #1;
    ph = q_h.pop_front();
    pw = q_w.pop_front();
    compare_one("halt_dut", ph, pc_h, instr_h, run_h, halt_h, cs_h);
    compare_one("wrap_dut", pw, pc_w, instr_w, run_w, halt_w, cs_w);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; start = 1'b0; load_we = 1'b0; load_addr = 2'd0;
    load_data = 3'd0; pcincr = 1'b0;
    #12;
    compare_one("reset_h", mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), pc_h, instr_h, run_h, halt_h, cs_h);
    compare_one("reset_w", mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), pc_w, instr_w, run_w, halt_w, cs_w);
    @(negedge clk);
    rst = 1'b0;

    // Load program {000,110,100,000} in IDLE.
    cycle(1'b0, 1'b1, 2'd0, 3'b000, 1'b0, mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    cycle(1'b0, 1'b1, 2'd1, 3'b110, 1'b0, mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    cycle(1'b0, 1'b1, 2'd2, 3'b100, 1'b0, mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    cycle(1'b0, 1'b1, 2'd3, 3'b000, 1'b0, mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    // pcincr ignored in IDLE.
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    // Start pulse.
    cycle(1'b1, 1'b0, 2'd0, 3'b000, 1'b0, mk(2'd0, 3'd0, 1'b1, 1'b0, 1'b1), mk(2'd0, 3'd0, 1'b1, 1'b0, 1'b1));
    // Write in RUN is ignored; pulse has ended.
    cycle(1'b0, 1'b1, 2'd1, 3'b111, 1'b0, mk(2'd0, 3'd0, 1'b1, 1'b0, 1'b0), mk(2'd0, 3'd0, 1'b1, 1'b0, 1'b0));
    // Step through the program.
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd1, 3'b110, 1'b1, 1'b0, 1'b0), mk(2'd1, 3'b110, 1'b1, 1'b0, 1'b0));
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd2, 3'b100, 1'b1, 1'b0, 1'b0), mk(2'd2, 3'b100, 1'b1, 1'b0, 1'b0));
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd3, 3'b000, 1'b1, 1'b0, 1'b0), mk(2'd3, 3'b000, 1'b1, 1'b0, 1'b0));
    // Last word: halt vs wrap.
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd3, 3'b000, 1'b0, 1'b1, 1'b0), mk(2'd0, 3'b000, 1'b1, 1'b0, 1'b0));
    // Further pcincr: halted pc holds, wrapped one keeps stepping.
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd3, 3'b000, 1'b0, 1'b1, 1'b0), mk(2'd1, 3'b110, 1'b1, 1'b0, 1'b0));
    // Write in HALT lands (halt_dut only).
    cycle(1'b0, 1'b1, 2'd1, 3'b111, 1'b0, mk(2'd3, 3'b000, 1'b0, 1'b1, 1'b0), mk(2'd1, 3'b110, 1'b1, 1'b0, 1'b0));
    // Restart from HALT; start ignored in RUN.
    cycle(1'b1, 1'b0, 2'd0, 3'b000, 1'b0, mk(2'd0, 3'b000, 1'b1, 1'b0, 1'b1), mk(2'd1, 3'b110, 1'b1, 1'b0, 1'b0));
    // Held start gives no second pulse.
    cycle(1'b1, 1'b0, 2'd0, 3'b000, 1'b0, mk(2'd0, 3'b000, 1'b1, 1'b0, 1'b0), mk(2'd1, 3'b110, 1'b1, 1'b0, 1'b0));
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd1, 3'b111, 1'b1, 1'b0, 1'b0), mk(2'd2, 3'b100, 1'b1, 1'b0, 1'b0));
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd2, 3'b100, 1'b1, 1'b0, 1'b0), mk(2'd3, 3'b000, 1'b1, 1'b0, 1'b0));

    // Asynchronous reset between edges, checked before any further edge.
    #2;
    rst = 1'b1;
    #1;
    compare_one("async_rst_h", mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), pc_h, instr_h, run_h, halt_h, cs_h);
    compare_one("async_rst_w", mk(2'd0, 3'd0, 1'b0, 1'b0, 1'b0), pc_w, instr_w, run_w, halt_w, cs_w);
    @(negedge clk);
    rst = 1'b0;

    // Load and start together: both take effect.
    cycle(1'b1, 1'b1, 2'd0, 3'b101, 1'b0, mk(2'd0, 3'b101, 1'b1, 1'b0, 1'b1), mk(2'd0, 3'b101, 1'b1, 1'b0, 1'b1));
    // Memory was cleared by reset: word 1 now reads 0.
    cycle(1'b0, 1'b0, 2'd0, 3'b000, 1'b1, mk(2'd1, 3'b000, 1'b1, 1'b0, 1'b0), mk(2'd1, 3'b000, 1'b1, 1'b0, 1'b0));

    check_eq("queue_h_drained", 32'(q_h.size()), 32'd0);
    check_eq("queue_w_drained", 32'(q_w.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bs_program_sequencer.md
Name: bs_program_sequencer

Overview:
- Instruction-supply end of the bit_serial core's fetch interface.
- Holds a small program memory of 3-bit instructions and a program counter that advances on the core's o_con_pcincr.
- Presents mem[pc] on the core's i_data_instruction and controls load, start and halt of program execution.
- Replaces the ad-hoc memory and counter used around the core in simulation with synthesizable RTL.

Parameters:
- DEPTH, 4, number of program words; must be a power of two, at least 2.
- INSTR_W, 3, instruction width; matches the core's i_data_instruction.
- WRAP, 0, 1 = pc wraps to 0 after the last word; 0 = halt after the last word.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  begin execution from address 0 (level sampled each cycle)
- i_load_we  in  1  program-memory write enable
- i_load_addr  in  $clog2(DEPTH)  write address
- i_load_data  in  INSTR_W  write data
- i_con_pcincr  in  1  pc increment request from the core
- o_data_instruction  out  INSTR_W  mem[pc], combinational read; drives the core
- o_core_start  out  1  one-cycle start pulse to the core
- o_pc  out  $clog2(DEPTH)  current program counter
- o_running  out  1  high in state RUN
- o_halted  out  1  high in state HALT

Behaviour:
- Reset (async, i_rst=1) sets:
  - state IDLE; pc=0; all memory words 0
  - o_core_start=0, o_running=0, o_halted=0
  - o_data_instruction=0
- States: IDLE, RUN, HALT. All state, pc and memory updates occur on posedge i_clk unless i_rst is high.
- Load:
  - When i_load_we=1 in IDLE or HALT, mem[i_load_addr] <= i_load_data.
  - i_load_we in RUN is ignored; memory is unchanged.
- o_data_instruction = mem[pc] at all times, including IDLE and HALT.
  - A write to the address equal to pc is visible on o_data_instruction the cycle after the write edge.
- Start:
  - i_start=1 in IDLE or HALT: next cycle state=RUN, pc=0, o_core_start=1 for exactly that one cycle.
  - i_start in RUN is ignored; no pulse, pc unchanged.
  - A held i_start produces only one pulse, because the block has left IDLE/HALT.
- Same cycle i_load_we=1 and i_start=1 in IDLE/HALT: both take effect. The write lands and RUN starts at pc=0.
- RUN, i_con_pcincr=1:
  - pc < DEPTH-1: pc <= pc+1.
  - pc = DEPTH-1, WRAP=1: pc <= 0, stay in RUN.
  - pc = DEPTH-1, WRAP=0: state <= HALT, pc holds DEPTH-1.
- i_con_pcincr is ignored in IDLE and HALT, and in the same cycle RUN is entered (o_core_start cycle excluded: the increment is evaluated only while state is already RUN).
- Increment latency: pc changes on the edge that samples i_con_pcincr=1; the new instruction is visible combinationally afterwards.
- HALT: o_halted=1, o_running=0. Only i_start (restart) or i_rst leaves HALT.
- Reset mid-RUN: immediate return to IDLE, pc=0, program memory cleared. Software must reload.
- o_running and o_halted are decoded directly from registered state, so they are glitch-free.

Decomposition:
- Shared package bs_pkg holds:
  - INSTR_W, the default instruction width
  - typedef seq_state_t enum {IDLE, RUN, HALT}
  - typedef instr_t logic [INSTR_W-1:0]
- One sub-module, bs_prog_mem:
  - DEPTH x INSTR_W array, async-reset clear
  - single synchronous write port, one combinational read port
- bs_program_sequencer holds the FSM, pc and start pulse, and instantiates bs_prog_mem.

Test Plan:
- Reset then load: load mem = {000,110,100,000} in IDLE, hold pcincr=0 -> o_pc=0, o_data_instruction=000, o_running=0, no o_core_start.
- Start: pulse i_start 1 cycle -> o_core_start high exactly 1 cycle, o_running=1. Then drive pcincr=1 for 3 cycles -> instructions 110, 100, 000 seen in order, o_pc=3.
- Halt at end (WRAP=0): pc=3, pcincr=1 -> o_halted=1, o_running=0, o_pc=3. A further pcincr leaves pc at 3.
- Wrap (WRAP=1): pc=3, pcincr=1 -> o_pc=0, o_data_instruction=000, o_running stays 1.
- Load ignored in RUN: in RUN write addr 1 = 111 -> mem[1] stays 110. After HALT, the same write gives 111 at pc=1 on restart.
- Async reset mid-RUN at pc=2: assert i_rst between clock edges -> o_pc=0, state IDLE and o_data_instruction=000 immediately, without waiting for a clock edge.
